// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store unit.
//   lsu_state_e   - memory-access FSM states
//   F3_*          - funct3 encodings for loads/stores (instr[14:12])
//   OPC_LOAD/STORE- major opcodes, shared with the core decoder
//   f3_valid()    - legality of a funct3 code for a load or a store
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  // Stores only have signed-width codes; loads add the unsigned variants.
  function automatic logic f3_valid(input logic we, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: core-side request/response and data-memory bus of the
// load/store unit.
//   req_*  : request from the core (valid/ready handshake)
//   rsp_*  : one-cycle completion pulse back to write-back
//   mem_*  : word-addressed data memory with read strobe / byte write mask
// Modports: slave = the load/store unit, master = core + memory side.
interface load_store_unit_if #(
  parameter int unsigned MEM_AW = 30
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_rstrb;
  logic [3:0]        mem_wmask;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_done;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  mem_rdata, mem_done,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_addr, mem_rstrb, mem_wmask, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    output mem_rdata, mem_done,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_addr, mem_rstrb, mem_wmask, mem_wdata
  );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: combinational lane logic for the load/store unit.
//   we, funct3, addr_lo : access kind and low address bits
//   wdata               : raw store data (rs2)
//   rdata               : word read from memory
//   wmask, wdata_rep    : byte enables and lane-replicated store data
//   load_data           : extracted, sign/zero-extended load result
//   invalid             : funct3 illegal for this access kind
//   misalign            : natural-alignment violation
// Build option: LSU_MISALIGN_TRAP_EN enables the misalign flag; without it
// the flag is 0 and low address bits are truncated to natural alignment.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wmask,
  output logic [31:0] wdata_rep,
  output logic [31:0] load_data,
  output logic        invalid,
  output logic        misalign
);

  logic [31:0] byte_sh;
  logic [31:0] half_sh;

  always_comb begin
    invalid = ~f3_valid(we, funct3);

    // Halfwords only look at addr[1], words ignore the low bits, so an
    // unaligned address silently truncates when no trap is built in.
    byte_sh = rdata >> {addr_lo, 3'b000};
    half_sh = rdata >> {addr_lo[1], 4'b0000};

    case (funct3[1:0])
      2'b00: begin
        wmask     = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      2'b01: begin
        wmask     = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
      end
      default: begin
        wmask     = 4'b1111;
        wdata_rep = wdata;
      end
    endcase

    case (funct3)
      F3_B:    load_data = {{24{byte_sh[7]}}, byte_sh[7:0]};
      F3_H:    load_data = {{16{half_sh[15]}}, half_sh[15:0]};
      F3_W:    load_data = rdata;
      F3_BU:   load_data = {24'h0, byte_sh[7:0]};
      F3_HU:   load_data = {16'h0, half_sh[15:0]};
      default: load_data = '0;
    endcase

`ifdef LSU_MISALIGN_TRAP_EN
    case (funct3[1:0])
      2'b01:   misalign = addr_lo[0];
      2'b10:   misalign = |addr_lo;
      default: misalign = 1'b0;
    endcase
`else
    misalign = 1'b0;
`endif
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage behind the RV32I EXECUTE state.
// Accepts one load/store at a time, drives a single-cycle read strobe or
// byte write mask, waits for mem_done (bounded by TIMEOUT_CYCLES) and
// returns a one-cycle rsp_valid pulse with extended data or an error.
//   clk     : system clock
//   resetn  : asynchronous active-low reset
//   bus     : load_store_unit_if.slave (req_*, rsp_*, mem_*)
// Parameters: TIMEOUT_CYCLES (1..255) wait-state budget, MEM_AW word-address
// width (<= 30).
// Build option: LSU_MISALIGN_TRAP_EN turns misaligned half/word accesses
// into errors instead of truncating the address.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter int unsigned MEM_AW         = 30
) (
  input  logic               clk,
  input  logic               resetn,
  load_store_unit_if.slave   bus
);

  lsu_state_e        state_q, state_d;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [1:0]        lo_q;
  logic [MEM_AW-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic [7:0]        cnt_q;

  logic              in_idle;
  logic              bad_req;
  logic              expired;

  logic              a_we;
  logic [2:0]        a_f3;
  logic [1:0]        a_lo;
  logic [3:0]        a_wmask;
  logic [31:0]       a_wdata;
  logic [31:0]       a_load;
  logic              a_invalid;
  logic              a_misalign;

  // One lane unit serves both phases: in IDLE it classifies the incoming
  // request, afterwards it works from the latched access.
  assign in_idle = (state_q == IDLE);
  assign a_we    = in_idle ? bus.req_we          : we_q;
  assign a_f3    = in_idle ? bus.req_funct3      : f3_q;
  assign a_lo    = in_idle ? bus.req_addr[1:0]   : lo_q;

  lsu_align u_align (
    .we        (a_we),
    .funct3    (a_f3),
    .addr_lo   (a_lo),
    .wdata     (bus.req_wdata),
    .rdata     (bus.mem_rdata),
    .wmask     (a_wmask),
    .wdata_rep (a_wdata),
    .load_data (a_load),
    .invalid   (a_invalid),
    .misalign  (a_misalign)
  );

  assign bad_req = a_invalid | a_misalign;
  assign expired = (cnt_q == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) state_d = bad_req ? RESP : ACCESS;
      end
      ACCESS: begin
        state_d = bus.mem_done ? RESP : WAIT;
      end
      WAIT: begin
        if (bus.mem_done || expired) state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = in_idle;
    bus.rsp_valid = (state_q == RESP);
    bus.rsp_err   = (state_q == RESP) & err_q;
    bus.rsp_rdata = rdata_q;
    bus.mem_addr  = mem_addr_q;
    bus.mem_wdata = mem_wdata_q;
    bus.mem_rstrb = (state_q == ACCESS) & ~we_q;
    bus.mem_wmask = ((state_q == ACCESS) && we_q) ? a_wmask : '0;
  end

  // Completion data is written only when entering RESP so that rsp_rdata
  // keeps the last result while the unit is idle or busy.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      we_q        <= 1'b0;
      f3_q        <= '0;
      lo_q        <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            we_q        <= bus.req_we;
            f3_q        <= bus.req_funct3;
            lo_q        <= bus.req_addr[1:0];
            mem_addr_q  <= bus.req_addr[2 +: MEM_AW];
            mem_wdata_q <= bus.req_we ? a_wdata : '0;
            if (bad_req) begin
              err_q   <= 1'b1;
              rdata_q <= '0;
            end
          end
        end
        ACCESS: begin
          cnt_q <= '0;
          if (bus.mem_done) begin
            err_q   <= 1'b0;
            rdata_q <= we_q ? '0 : a_load;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q + 8'd1;
          if (bus.mem_done) begin
            err_q   <= 1'b0;
            rdata_q <= we_q ? '0 : a_load;
          end else if (expired) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
